// File: rtl/motion_pkg.sv
// Shared constants and helpers for the 1-D motion integrator.
// Boundary mode encodings and a width-generic saturating negate.
package motion_pkg;

    localparam logic [1:0] MODE_FREE   = 2'd0;
    localparam logic [1:0] MODE_CLAMP  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    // Working width for sat_neg; callers sign-extend into it and truncate back.
    localparam int SAT_W = 64;

    // Negate a w-bit signed value carried in SAT_W bits; the most negative
    // w-bit value maps to the most positive instead of wrapping onto itself.
    function automatic logic signed [SAT_W-1:0] sat_neg(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] mn;
        mn = -(64'sd1 <<< (w - 1));
        if (x == mn)
            sat_neg = -mn - 64'sd1;
        else
            sat_neg = -x;
    endfunction

endpackage

// File: rtl/motion_integrator_sat_add.sv
// Signed saturating adder: clips to the representable range instead of
// wrapping. Used for both the velocity and the position update.
module sat_add #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] full;

    assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

    // The two top bits of the extended sum disagree exactly on overflow.
    always_comb begin
        sum_o = full[W-1:0];
        if (full[W] != full[W-1])
            sum_o = full[W] ? SMIN : SMAX;
    end

endmodule

// File: rtl/motion_integrator.sv
// Fixed-point 1-D motion integrator (semi-implicit Euler) with free, clamp
// or bounce handling at the position bounds. MOTION_BOUNCE_DAMP_EN enables
// damped bounces.
module motion_integrator
    import motion_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FRAC_BITS  = 8,
    parameter int LOAD_W     = 10,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 100,
    parameter int POS_INIT   = 50,
    parameter int VEL_INIT   = 0,
    parameter int DAMP_SHIFT = 2
) (
    input  logic              CLK,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [LOAD_W-1:0] i_load_pos,
    input  logic              i_snap_min,
    input  logic              i_snap_max,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_accel,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_pos,
    output logic [DATA_W-1:0] o_vel,
    output logic              o_valid,
    output logic              o_hit_min,
    output logic              o_hit_max
);

`ifdef MOTION_BOUNCE_DAMP_EN
    localparam bit DAMP_EN = 1'b1;
`else
    localparam bit DAMP_EN = 1'b0;
`endif

    localparam logic signed [DATA_W-1:0] MINF  = DATA_W'(POS_MIN) << FRAC_BITS;
    localparam logic signed [DATA_W-1:0] MAXF  = DATA_W'(POS_MAX) << FRAC_BITS;
    localparam logic signed [DATA_W-1:0] PINIT = DATA_W'(POS_INIT) << FRAC_BITS;
    localparam logic signed [DATA_W-1:0] VINIT = DATA_W'(VEL_INIT);

    logic signed [DATA_W-1:0] pos_q, pos_d;
    logic signed [DATA_W-1:0] vel_q, vel_d;
    logic                     valid_q, valid_d;
    logic                     hmin_q, hmin_d;
    logic                     hmax_q, hmax_d;

    logic signed [DATA_W-1:0] v_nxt, p_nxt;
    logic signed [DATA_W-1:0] v_damp, v_bnc;
    logic signed [DATA_W-1:0] accel_s;

    assign accel_s = i_accel;

    sat_add #(.W(DATA_W)) u_vel_add (
        .a_i   (vel_q),
        .b_i   (accel_s),
        .sum_o (v_nxt)
    );

    // Position integrates the freshly updated velocity (semi-implicit).
    sat_add #(.W(DATA_W)) u_pos_add (
        .a_i   (pos_q),
        .b_i   (v_nxt),
        .sum_o (p_nxt)
    );

    // v - (v >>> k) moves toward zero, so it cannot overflow itself.
    assign v_damp = v_nxt - (v_nxt >>> DAMP_SHIFT);
    assign v_bnc  = DATA_W'(sat_neg(SAT_W'(DAMP_EN ? v_damp : v_nxt), DATA_W));

    always_comb begin
        pos_d   = pos_q;
        vel_d   = vel_q;
        valid_d = 1'b0;
        hmin_d  = 1'b0;
        hmax_d  = 1'b0;
        if (i_load) begin
            pos_d = DATA_W'(i_load_pos) << FRAC_BITS;
            vel_d = '0;
        end else if (i_snap_min) begin
            pos_d = MINF;
            vel_d = '0;
        end else if (i_snap_max) begin
            pos_d = MAXF;
            vel_d = '0;
        end else if (i_step) begin
            valid_d = 1'b1;
            pos_d   = p_nxt;
            vel_d   = v_nxt;
            if (i_mode != MODE_FREE) begin
                if (p_nxt < MINF) begin
                    pos_d  = MINF;
                    hmin_d = 1'b1;
                    vel_d  = (i_mode == MODE_BOUNCE) ? v_bnc : '0;
                end else if (p_nxt > MAXF) begin
                    pos_d  = MAXF;
                    hmax_d = 1'b1;
                    vel_d  = (i_mode == MODE_BOUNCE) ? v_bnc : '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pos_q   <= PINIT;
            vel_q   <= VINIT;
            valid_q <= 1'b0;
            hmin_q  <= 1'b0;
            hmax_q  <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            vel_q   <= vel_d;
            valid_q <= valid_d;
            hmin_q  <= hmin_d;
            hmax_q  <= hmax_d;
        end
    end

    assign o_pos     = pos_q >>> FRAC_BITS;
    assign o_vel     = vel_q;
    assign o_valid   = valid_q;
    assign o_hit_min = hmin_q;
    assign o_hit_max = hmax_q;

endmodule

// File: tb/tb_motion_integrator.sv
// Table-driven bench for motion_integrator with a scoreboard queue of
// expected output records.
module tb_motion_integrator;

    logic        CLK = 1'b0;
    logic        i_rst_n;
    logic        i_load;
    logic [9:0]  i_load_pos;
    logic        i_snap_min;
    logic        i_snap_max;
    logic        i_step;
    logic [31:0] i_accel;
    logic [1:0]  i_mode;
    logic [31:0] o_pos;
    logic [31:0] o_vel;
    logic        o_valid;
    logic        o_hit_min;
    logic        o_hit_max;

    int checks   = 0;
    int failures = 0;

`ifdef MOTION_BOUNCE_DAMP_EN
    localparam int BNC_MAX  = -384;
    localparam int BNC_MIN  = 384;
    localparam int FREE_POS = 1;
    localparam int NEG_SAT  = 1610612736;
`else
    localparam int BNC_MAX  = -512;
    localparam int BNC_MIN  = 512;
    localparam int FREE_POS = 2;
    localparam int NEG_SAT  = 32'h7FFFFFFF;
`endif

    typedef struct {
        logic        ld;
        logic [9:0]  lpos;
        logic        smin;
        logic        smax;
        logic        step;
        logic [31:0] acc;
        logic [1:0]  mode;
        int          epos;
        int          evel;
        logic        evld;
        logic        ehmin;
        logic        ehmax;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl[NV];
    vec_t sb[$];

    motion_integrator dut (
        .CLK        (CLK),
        .i_rst_n    (i_rst_n),
        .i_load     (i_load),
        .i_load_pos (i_load_pos),
        .i_snap_min (i_snap_min),
        .i_snap_max (i_snap_max),
        .i_step     (i_step),
        .i_accel    (i_accel),
        .i_mode     (i_mode),
        .o_pos      (o_pos),
        .o_vel      (o_vel),
        .o_valid    (o_valid),
        .o_hit_min  (o_hit_min),
        .o_hit_max  (o_hit_max)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t V(input bit ld, input int lpos, input bit smin, input bit smax,
                               input bit step, input int acc, input int mode, input int epos,
                               input int evel, input bit evld, input bit ehmin, input bit ehmax);
        vec_t v;
        v.ld = ld; v.lpos = 10'(lpos); v.smin = smin; v.smax = smax; v.step = step;
        v.acc = 32'(acc); v.mode = 2'(mode);
        v.epos = epos; v.evel = evel; v.evld = evld; v.ehmin = ehmin; v.ehmax = ehmax;
        return v;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_load = 0; i_load_pos = '0; i_snap_min = 0; i_snap_max = 0;
        i_step = 0; i_accel = '0; i_mode = 2'd1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        @(negedge CLK);
        i_load = v.ld; i_load_pos = v.lpos; i_snap_min = v.smin; i_snap_max = v.smax;
        i_step = v.step; i_accel = v.acc; i_mode = v.mode;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        idle_inputs();
        if (sb.size() == 0) begin
            cmp({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            cmp({tag, "_pos"},  $signed(o_pos), e.epos);
            cmp({tag, "_vel"},  $signed(o_vel), e.evel);
            cmp({tag, "_vld"},  o_valid,   e.evld);
            cmp({tag, "_hmin"}, o_hit_min, e.ehmin);
            cmp({tag, "_hmax"}, o_hit_max, e.ehmax);
        end
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_pos"},  $signed(o_pos), 50);
        cmp({tag, "_vel"},  $signed(o_vel), 0);
        cmp({tag, "_vld"},  o_valid,   0);
        cmp({tag, "_hmin"}, o_hit_min, 0);
        cmp({tag, "_hmax"}, o_hit_max, 0);
    endtask

    initial begin
        //           ld lpos smin smax step acc  mode  pos  vel  vld hmin hmax
        tbl[0]  = V(0, 0,  0, 0, 1, -256, 1, 49, -256, 1, 0, 0);
        tbl[1]  = V(0, 0,  0, 0, 1, -256, 1, 47, -512, 1, 0, 0);
        tbl[2]  = V(0, 0,  0, 0, 1, -256, 1, 44, -768, 1, 0, 0);
        tbl[3]  = V(0, 0,  0, 0, 0, 0,    1, 44, -768, 0, 0, 0);
        tbl[4]  = V(1, 1,  0, 0, 0, 0,    1, 1,  0,    0, 0, 0);
        tbl[5]  = V(0, 0,  0, 0, 1, -512, 1, 0,  0,    1, 1, 0);
        tbl[6]  = V(0, 0,  0, 0, 0, 0,    1, 0,  0,    0, 0, 0);
        tbl[7]  = V(1, 99, 0, 0, 0, 0,    2, 99, 0,    0, 0, 0);
        tbl[8]  = V(0, 0,  0, 0, 1, 512,  2, 100, BNC_MAX, 1, 0, 1);
        tbl[9]  = V(0, 0,  0, 0, 0, 0,    2, 100, BNC_MAX, 0, 0, 0);
        tbl[10] = V(1, 30, 0, 1, 1, 512,  1, 30, 0,    0, 0, 0);
        tbl[11] = V(0, 0,  1, 1, 1, 512,  1, 0,  0,    0, 0, 0);
        tbl[12] = V(0, 0,  0, 1, 1, 512,  1, 100, 0,   0, 0, 0);
        tbl[13] = V(1, 99, 0, 0, 0, 0,    1, 99, 0,    0, 0, 0);
        tbl[14] = V(0, 0,  0, 0, 1, 256,  1, 100, 256, 1, 0, 0);
        tbl[15] = V(0, 0,  0, 0, 1, 0,    3, 100, 0,   1, 0, 1);
        tbl[16] = V(1, 1,  0, 0, 0, 0,    2, 1,  0,    0, 0, 0);
        tbl[17] = V(0, 0,  0, 0, 1, -512, 2, 0,  BNC_MIN, 1, 1, 0);
        tbl[18] = V(0, 0,  0, 0, 1, 0,    0, FREE_POS, BNC_MIN, 1, 0, 0);
        tbl[19] = V(0, 0,  1, 0, 0, 0,    0, 0,  0,    0, 0, 0);
        tbl[20] = V(0, 0,  0, 0, 1, -256, 0, -1, -256, 1, 0, 0);

        idle_inputs();
        i_rst_n = 1'b0;
        #12;
        check_reset_state("por");
        @(negedge CLK);
        i_rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // Pending valid/hit pulse must vanish as soon as reset asserts.
        run_vec(V(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0), "pre_rst");
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge CLK);
        i_rst_n = 1'b1;

        for (int i = 0; i < 3; i++)
            run_vec(V(0, 0, 0, 0, 1, 32'h7FFFFFFF, 0, 8388607, 32'h7FFFFFFF, 1, 0, 0),
                    $sformatf("satp%0d", i));

        @(negedge CLK);
        i_rst_n = 1'b0;
        @(negedge CLK);
        i_rst_n = 1'b1;
        run_vec(V(0, 0, 0, 0, 1, 32'h80000000, 0, -8388558, 32'h80000000, 1, 0, 0), "satn");
        run_vec(V(0, 0, 0, 0, 1, 0, 2, 0, NEG_SAT, 1, 1, 0), "satn_bnc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
